// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO word reader.
// Holds the byte width default and the reader FSM encoding.
package fifo_pkg;

  localparam int BYTE_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

endpackage

// File: rtl/word_out_reg.sv
// Output holding register with valid/ready handshake.
// Reports when it can accept a new word this cycle.
module word_out_reg #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic [KW-1:0] keep_i,
  input  logic          last_i,
  input  logic          m_ready_i,
  output logic          m_valid_o,
  output logic [DW-1:0] m_data_o,
  output logic [KW-1:0] m_keep_o,
  output logic          m_last_o,
  output logic          free_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [KW-1:0] keep_q;
  logic          last_q;

  assign free_o    = !valid_q || m_ready_i;
  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_keep_o  = keep_q;
  assign m_last_o  = last_q;

  // Load a new word when free, otherwise drop valid after a transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
      last_q  <= last_i;
    end else if (valid_q && m_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_word_reader.sv
// Reads bytes from an 8-bit FIFO and packs them into words.
// A flush closes a partial word with a keep mask and last flag.
module fifo_word_reader
  import fifo_pkg::*;
#(
  parameter int BYTE_W         = BYTE_W_DEF,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             fifo_rd_en,
  input  logic [BYTE_W-1:0]                fifo_data,
  input  logic                             fifo_empty,
  input  logic                             flush,
  output logic                             busy,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] m_data,
  output logic [BYTES_PER_WORD-1:0]        m_keep,
  output logic                             m_last
);

  localparam int BPW = BYTES_PER_WORD;
  localparam int CW  = $clog2(BPW + 1);

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         inflight_q;
  logic [BPW-1:0][BYTE_W-1:0]   pack_q, pack_d;
  logic [BPW-1:0][BYTE_W-1:0]   ld_data;
  logic [BPW-1:0]               ld_keep;
  logic                         ld_last;
  logic                         load;
  logic                         out_free;
  logic                         full;
  logic [CW:0]                  occ;

  assign full = (cnt_q == CW'(BPW));
  assign occ  = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
  assign busy = (state_q != ST_FILL);

  assign fifo_rd_en = rst && (state_q == ST_FILL) && !fifo_empty
                      && (occ < (CW+1)'(BPW));

  // Lanes past the byte count are zeroed so partial words are clean.
  always_comb begin
    for (int i = 0; i < BPW; i++) begin
      ld_keep[i] = (CW'(i) < cnt_q);
      ld_data[i] = pack_q[i] & {BYTE_W{ld_keep[i]}};
    end
  end

  // Next-state: byte capture, word hand-off and flush sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pack_d  = pack_q;
    load    = 1'b0;
    ld_last = 1'b0;
    for (int i = 0; i < BPW; i++) begin
      if (inflight_q && cnt_q == CW'(i)) pack_d[i] = fifo_data;
    end
    if (inflight_q) cnt_d = cnt_q + CW'(1);
    unique case (state_q)
      ST_FILL: begin
        if (full && out_free) load = 1'b1;
        if (flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!inflight_q) begin
          if (cnt_q == '0) begin
            state_d = ST_FILL;
          end else if (full) begin
            if (out_free) begin
              load    = 1'b1;
              ld_last = 1'b1;
              state_d = ST_FILL;
            end
          end else begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (out_free) begin
          load    = 1'b1;
          ld_last = 1'b1;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
    if (load) cnt_d = '0;
  end

  // State, counter, in-flight flag and pack register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_FILL;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      pack_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= fifo_rd_en;
      pack_q     <= pack_d;
    end
  end

  word_out_reg #(
    .DW(BYTE_W * BPW),
    .KW(BPW)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .data_i   (ld_data),
    .keep_i   (ld_keep),
    .last_i   (ld_last),
    .m_ready_i(m_ready),
    .m_valid_o(m_valid),
    .m_data_o (m_data),
    .m_keep_o (m_keep),
    .m_last_o (m_last),
    .free_o   (out_free)
  );

endmodule

// File: tb/tb_fifo_word_reader.sv
// Scoreboard bench for fifo_word_reader.
// Byte stream model predicts words; monitor checks transfers.
module tb_fifo_word_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_rd_en;
  logic [7:0]  fifo_data = '0;
  logic        fifo_empty = 1'b1;
  logic        flush = 1'b0;
  logic        busy;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  fifo_q[$];
  logic [7:0]  part[$];
  int          total = 0;
  int          bad = 0;
  int          reads_n = 0;
  int          rdy_mode = 0;
  logic        hold_ne = 1'b0;

  fifo_word_reader dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_rd_en(fifo_rd_en),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .flush     (flush),
    .busy      (busy),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      total++;
      if (fifo_q.size() == 0) begin
        bad++;
        $display("FAIL rd_on_empty: rd_en=1 required no read");
      end else begin
        fifo_data <= fifo_q.pop_front();
        reads_n++;
      end
    end
    fifo_empty <= hold_ne ? 1'b0 : (fifo_q.size() == 0);
  end

  // Downstream ready driver.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_ready = 1'b0;
      1: m_ready = 1'b1;
      default: m_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor: pops expected words on transfers, checks hold stability.
  logic        stall_q = 1'b0;
  logic [31:0] pd;
  logic [3:0]  pk;
  logic        pl;
  always @(negedge clk) begin
    exp_t e;
    if (stall_q && rst) begin
      total++;
      if (!m_valid || m_data !== pd || m_keep !== pk || m_last !== pl) begin
        bad++;
        $display("FAIL hold: v=%b d=%h k=%h l=%b required v=1 d=%h k=%h l=%b",
                 m_valid, m_data, m_keep, m_last, pd, pk, pl);
      end
    end
    if (rst && m_valid && m_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_word: d=%h k=%h l=%b required none",
                 m_data, m_keep, m_last);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e.d || m_keep !== e.k || m_last !== e.l) begin
          bad++;
          $display("FAIL word: d=%h k=%h l=%b required d=%h k=%h l=%b",
                   m_data, m_keep, m_last, e.d, e.k, e.l);
        end
      end
    end
    stall_q = rst && m_valid && !m_ready;
    pd = m_data;
    pk = m_keep;
    pl = m_last;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_flush();
    exp_t e;
    if (part.size() > 0) begin
      e.d = '0;
      e.k = '0;
      for (int i = 0; i < part.size(); i++) begin
        e.d[i*8 +: 8] = part[i];
        e.k[i] = 1'b1;
      end
      e.l = 1'b1;
      exp_q.push_back(e);
      part.delete();
    end
  endtask

  task automatic push_raw(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    exp_t e;
    push_raw(b);
    part.push_back(b);
    if (part.size() == 4) begin
      e.d = {part[3], part[2], part[1], part[0]};
      e.k = 4'hF;
      e.l = 1'b0;
      exp_q.push_back(e);
      part.delete();
    end
  endtask

  task automatic quiesce();
    int n;
    rdy_mode = 1;
    n = 0;
    while (fifo_q.size() != 0 && n < 2000) begin
      step(1);
      n++;
    end
    if (fifo_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: left=%0d required 0", fifo_q.size());
    end
    step(12);
  endtask

  task automatic do_flush();
    int n;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      step(1);
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL busy_stuck: busy=1 required 0");
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  initial begin
    int bcnt;
    // 1: reset with FIFO claiming data
    rst = 1'b0;
    hold_ne = 1'b1;
    fifo_empty = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'h0);
      chk("rst_valid", 32'(m_valid), 32'h0);
      chk("rst_keep", 32'(m_keep), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end
    step(1);
    hold_ne = 1'b0;
    fifo_empty = 1'b1;
    rst = 1'b1;
    step(2);

    // 2: one word, four reads
    reads_n = 0;
    rdy_mode = 1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    quiesce();
    chk("read_count", 32'(reads_n), 32'd4);

    // 3: backpressure
    rdy_mode = 0;
    step(2);
    for (int i = 1; i <= 12; i++) push(8'(i));
    step(30);
    chk("bp_left", 32'(fifo_q.size()), 32'd4);
    chk("bp_valid", 32'(m_valid), 32'h1);
    chk("bp_data", m_data, 32'h04030201);
    quiesce();

    // 4: partial flush
    push(8'hAA); push(8'hBB);
    quiesce();
    model_flush();
    do_flush();
    step(4);

    // 5: empty flush then flush on the 4th read
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    bcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    step(1);
    total++;
    if (bcnt > 2) begin
      bad++;
      $display("FAIL busy_len: got %0d required <=2", bcnt);
    end
    push(8'hC1); push(8'hC2); push(8'hC3);
    quiesce();
    push_raw(8'hC4);
    part.push_back(8'hC4);
    model_flush();
    do_flush();
    step(6);

    // 6: reset discards a partial word
    push(8'hD1); push(8'hD2); push(8'hD3);
    quiesce();
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    part.delete();
    chk("post_rst_valid", 32'(m_valid), 32'h0);
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    quiesce();

    // random traffic with occasional flushes
    for (int blk = 0; blk < 8; blk++) begin
      int n;
      rdy_mode = 2;
      n = $urandom_range(5, 40);
      for (int j = 0; j < n; j++) begin
        push(8'($urandom));
        step($urandom_range(0, 2));
      end
      quiesce();
      if ($urandom_range(0, 1) == 1) begin
        model_flush();
        do_flush();
        step(4);
      end
    end
    quiesce();
    chk("exp_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
